// File: rtl/ewb_control_if.sv
// Handshake bundle between the eviction write buffer controller, the L2 cache
// port and the physical-memory port.
interface ewb_control_if;
    logic ewb_read_i;
    logic ewb_write_i;
    logic ewb_resp_o;
    logic pmem_read_o;
    logic pmem_write_o;
    logic pmem_resp_i;

    modport slave (
        input  ewb_read_i,
        input  ewb_write_i,
        input  pmem_resp_i,
        output ewb_resp_o,
        output pmem_read_o,
        output pmem_write_o
    );

    modport master (
        output ewb_read_i,
        output ewb_write_i,
        output pmem_resp_i,
        input  ewb_resp_o,
        input  pmem_read_o,
        input  pmem_write_o
    );
endinterface

// File: rtl/ewb_control.sv
// Control FSM for the single-entry eviction write buffer: absorbs writebacks,
// serves read hits, forwards misses and drains the entry on conflict or idle.
module ewb_control #(
    parameter int unsigned IDLE_DRAIN = 8
) (
    input  logic               clk,
    input  logic               rst,
    ewb_control_if.slave       bus,
    input  logic               valid_i,
    input  logic               addr_hit_i,
    output logic               ld_data_addr_o,
    output logic               ld_status_o,
    output logic               status_o,
    output logic               rdata_sel_o,
    output logic               addr_sel_o
);

    localparam int unsigned    CW     = $clog2(IDLE_DRAIN + 1);
    localparam logic [CW-1:0]  THRESH = CW'(IDLE_DRAIN - 1);
    localparam logic [CW-1:0]  SAT    = CW'(IDLE_DRAIN);

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        READ_MEM,
        EVICT,
        DRAIN
    } state_t;

    state_t          state;
    logic [CW-1:0]   drain_cnt;
    logic            rdata_flag;
    logic            idle_cond;

    assign idle_cond = (state == IDLE) && valid_i && !bus.ewb_read_i && !bus.ewb_write_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            rdata_flag <= 1'b0;
        end else begin
            if (!idle_cond)
                drain_cnt <= '0;
            else if (drain_cnt != SAT)
                drain_cnt <= drain_cnt + 1'b1;

            case (state)
                IDLE: begin
                    // Read has priority over a (illegal) simultaneous write.
                    if (bus.ewb_read_i) begin
                        if (valid_i && addr_hit_i) begin
                            rdata_flag <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= READ_MEM;
                        end
                    end else if (bus.ewb_write_i) begin
                        if (!valid_i || addr_hit_i) begin
                            rdata_flag <= 1'b0;
                            state      <= RESP;
                        end else begin
                            state <= EVICT;
                        end
                    end else if (idle_cond && drain_cnt == THRESH) begin
                        state <= DRAIN;
                    end
                end
                RESP: begin
                    rdata_flag <= 1'b0;
                    state      <= IDLE;
                end
                READ_MEM: if (bus.pmem_resp_i) state <= IDLE;
                EVICT: begin
                    if (bus.pmem_resp_i) begin
                        rdata_flag <= 1'b0;
                        state      <= RESP;
                    end
                end
                DRAIN:    if (bus.pmem_resp_i) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by rst so they drop the instant reset is applied.
    always_comb begin
        bus.ewb_resp_o   = 1'b0;
        bus.pmem_read_o  = 1'b0;
        bus.pmem_write_o = 1'b0;
        ld_data_addr_o   = 1'b0;
        ld_status_o      = 1'b0;
        status_o         = 1'b0;
        rdata_sel_o      = 1'b0;
        addr_sel_o       = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!bus.ewb_read_i && bus.ewb_write_i && (!valid_i || addr_hit_i)) begin
                        ld_data_addr_o = 1'b1;
                        ld_status_o    = 1'b1;
                        status_o       = 1'b1;
                    end
                end
                RESP: begin
                    bus.ewb_resp_o = 1'b1;
                    rdata_sel_o    = rdata_flag;
                end
                READ_MEM: begin
                    bus.pmem_read_o = 1'b1;
                    bus.ewb_resp_o  = bus.pmem_resp_i;
                end
                EVICT: begin
                    bus.pmem_write_o = 1'b1;
                    addr_sel_o       = 1'b1;
                    if (bus.pmem_resp_i) begin
                        ld_data_addr_o = 1'b1;
                        ld_status_o    = 1'b1;
                        status_o       = 1'b1;
                    end
                end
                DRAIN: begin
                    bus.pmem_write_o = 1'b1;
                    addr_sel_o       = 1'b1;
                    ld_status_o      = bus.pmem_resp_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ewb_control.md
Name: ewb_control

Overview:
- FSM sequencing the single-entry eviction write buffer datapath (address/data/status registers) between the L2 cache (lower port) and physical memory (upper port).
- Absorbs dirty-line writebacks in one cycle and serves read hits from the buffer.
- Forwards read misses to memory.
- Drains the buffered line to memory on a write conflict or after a programmable idle period.

Parameters:
IDLE_DRAIN, 8, consecutive idle cycles with a valid entry before an autonomous drain starts; legal range >= 1.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-high reset.
ewb_read_i  input  1  cache read request; held until ewb_resp_o.
ewb_write_i  input  1  cache writeback request; held until ewb_resp_o.
ewb_resp_o  output  1  one-cycle completion pulse to the cache.
pmem_read_o  output  1  memory read request.
pmem_write_o  output  1  memory write request, carrying buffered line/address.
pmem_resp_i  input  1  memory completion pulse.
valid_i  input  1  status register output from the datapath (1 = dirty entry held).
addr_hit_i  input  1  datapath compare: ewb_address_i == buffered address.
ld_data_addr_o  output  1  load address and data registers from the cache port.
ld_status_o  output  1  load the status register.
status_o  output  1  value written into the status register.
rdata_sel_o  output  1  1 = return buffered data to cache; 0 = return memory data.
addr_sel_o  output  1  1 = drive buffered address to memory; 0 = pass cache address through.

Behaviour:
- Reset (async, rst=1): state=IDLE, drain counter=0, rdata flag=0; all outputs 0. The datapath clears status on the same rst. Reset mid-transaction abandons it with no response.
- States: IDLE, RESP, READ_MEM, EVICT, DRAIN. Outputs are combinational from state, inputs and the registered rdata flag.
- IDLE, read priority (read and write together is illegal; read wins):
  - Read with valid_i && addr_hit_i: set rdata flag=1, go to RESP.
  - Read otherwise: go to READ_MEM.
- IDLE, write:
  - Write with !valid_i, or with valid_i && addr_hit_i (coalesce): in that cycle assert ld_data_addr_o=1, ld_status_o=1, status_o=1; set rdata flag=0; go to RESP.
  - Write with valid_i && !addr_hit_i: go to EVICT.
- RESP: ewb_resp_o=1 for exactly one cycle; rdata_sel_o=rdata flag. Next state IDLE; flag cleared.
- READ_MEM:
  - Drives pmem_read_o=1, addr_sel_o=0, rdata_sel_o=0.
  - On pmem_resp_i: ewb_resp_o=1 in the same cycle, then IDLE.
  - The buffer entry is untouched.
- EVICT:
  - Drives pmem_write_o=1, addr_sel_o=1.
  - On pmem_resp_i: in the same cycle assert ld_data_addr_o=1, ld_status_o=1, status_o=1 to capture the new line; go to RESP.
- DRAIN:
  - Drives pmem_write_o=1, addr_sel_o=1.
  - On pmem_resp_i: ld_status_o=1, status_o=0, then IDLE.
  - Cache requests arriving during DRAIN are not accepted and wait in IDLE afterward.
- Drain counter, width $clog2(IDLE_DRAIN+1), saturating:
  - Increments each cycle in IDLE with valid_i=1 and no request.
  - Clears in every other cycle.
  - When counter==IDLE_DRAIN-1 and the idle condition holds, next state is DRAIN. pmem_write_o rises the cycle after the IDLE_DRAIN-th consecutive idle cycle.
  - A request in the same cycle as the threshold wins; the counter clears.
- Memory requests stay asserted until pmem_resp_i. pmem_read_o and pmem_write_o are never asserted together.
- ewb_resp_o never asserts without a pending request.

Test Plan:
1. Reset, then write A into an empty buffer → ld_data_addr_o=ld_status_o=status_o=1 in the request cycle; ewb_resp_o one cycle later (latency 1); buffer valid.
2. Buffer holds A, read A → ewb_resp_o=1 with rdata_sel_o=1 at latency 1; no pmem activity. Read B → pmem_read_o with addr_sel_o=0 until pmem_resp_i; ewb_resp_o in the same cycle; buffer still holds A.
3. Buffer holds A, write B → pmem_write_o with addr_sel_o=1; memory responds after 5 cycles → B loaded and status=1 in the response cycle, ewb_resp_o the next cycle. Write B again → coalesced, no pmem traffic.
4. IDLE_DRAIN=8, buffer valid, no requests → pmem_write_o rises after exactly 8 idle cycles; on pmem_resp_i, status_o=0 with ld_status_o=1. A request at idle cycle 5 restarts the count from 0.
5. Request raised during DRAIN → no ewb_resp_o until the drain completes; then serviced normally (read B goes to memory).
6. Assert rst while in EVICT → all outputs 0 immediately (async), state IDLE, counter 0, no ewb_resp_o.
